// File: rtl/imem_boot_sequencer.sv
// Arbitrates the single L1 instruction-memory port between the boot loader and the core IF stage.
// The loader stream is written to consecutive words, then the core is released and its fetches are forwarded.
module imem_boot_sequencer #(
  parameter int          DEPTH   = 128,
  parameter int          CNT_W   = 8,
  parameter logic [63:0] BOOT_PC = 64'd0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             boot_start,
  input  logic             ld_valid,
  input  logic [31:0]      ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  input  logic [63:0]      pc_if,
  input  logic             pc_stall,
  output logic [63:0]      mem_addr,
  output logic             mem_en,
  output logic             mem_we,
  output logic [31:0]      mem_wdata,
  input  logic             mem_fault,
  output logic             core_hold,
  output logic             core_run,
  output logic             seq_fault,
  output logic [CNT_W-1:0] ld_count
);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, FAULT} state_t;

  state_t           state, state_nx;
  logic             core_hold_nx, core_run_nx, seq_fault_nx;
  logic [CNT_W-1:0] ld_count_nx;
  logic             xfer, full;

  // Gated by rstn so nothing is accepted or written while reset is held.
  assign ld_ready = rstn && (state == LOAD);
  assign xfer     = ld_valid && ld_ready;
  assign full     = (ld_count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      core_hold <= 1'b1;
      core_run  <= 1'b0;
      seq_fault <= 1'b0;
      ld_count  <= '0;
    end else begin
      state     <= state_nx;
      core_hold <= core_hold_nx;
      core_run  <= core_run_nx;
      seq_fault <= seq_fault_nx;
      ld_count  <= ld_count_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    core_hold_nx = core_hold;
    core_run_nx  = core_run;
    seq_fault_nx = seq_fault;
    ld_count_nx  = ld_count;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state)
      IDLE: begin
        if (boot_start) begin
          state_nx    = LOAD;
          ld_count_nx = '0;
        end
      end
      LOAD: begin
        if (xfer) begin
          if (full) begin
            // Image larger than the memory: drop the word, never wrap the count.
            seq_fault_nx = 1'b1;
            state_nx     = FAULT;
          end else begin
            mem_en      = 1'b1;
            mem_we      = 1'b1;
            mem_addr    = BOOT_PC + (64'(ld_count) << 2);
            mem_wdata   = ld_data;
            ld_count_nx = ld_count + CNT_W'(1);
            if (ld_last) state_nx = SETTLE;
          end
        end
      end
      SETTLE: begin
        state_nx     = RUN;
        core_hold_nx = 1'b0;
        core_run_nx  = 1'b1;
      end
      RUN: begin
        mem_addr = pc_if;
        mem_en   = ~pc_stall;
        // A reload request takes priority over a fault arriving the same cycle.
        if (boot_start) begin
          state_nx     = LOAD;
          core_hold_nx = 1'b1;
          core_run_nx  = 1'b0;
          ld_count_nx  = '0;
        end else if (mem_fault) begin
          state_nx     = FAULT;
          seq_fault_nx = 1'b1;
          core_hold_nx = 1'b1;
          core_run_nx  = 1'b0;
        end
      end
      FAULT: begin
        if (boot_start) begin
          state_nx     = LOAD;
          seq_fault_nx = 1'b0;
          ld_count_nx  = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!rstn) begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Directed-sequence bench with randomized images/fetches; a word-array reference of the loaded
// image and simple count rules provide all expected values.
module tb_imem_boot_sequencer;
  localparam int DEPTH = 128;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rstn, boot_start, ld_valid, ld_last, ld_ready;
  logic [31:0]      ld_data, mem_wdata;
  logic [63:0]      pc_if, mem_addr;
  logic             pc_stall, mem_en, mem_we, mem_fault;
  logic             core_hold, core_run, seq_fault;
  logic [CNT_W-1:0] ld_count;

  imem_boot_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .BOOT_PC(64'd0)) dut (
    .clk(clk), .rstn(rstn), .boot_start(boot_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .pc_if(pc_if), .pc_stall(pc_stall),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_fault(mem_fault), .core_hold(core_hold), .core_run(core_run),
    .seq_fault(seq_fault), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  // Instruction memory stand-in: records every write the sequencer performs.
  logic [31:0] imem [DEPTH];
  int          wr_cnt = 0;
  int          bad_addr = 0;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wr_cnt <= wr_cnt + 1;
      if (mem_addr < 64'(DEPTH * 4)) imem[mem_addr[8:2]] <= mem_wdata;
      else bad_addr <= bad_addr + 1;
    end
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] src [DEPTH + 1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Streams src[0..n-1]; optional idle gaps (with ignored boot_start pulses) between words.
  task automatic load(input int n, input bit use_last, input bit gaps, input bit pulse,
                      input bit skip_boot);
    int w0, nw, bad;
    w0 = wr_cnt;
    nw = (n < DEPTH) ? n : DEPTH;
    if (!skip_boot) begin
      boot_start = 1'b1;
      tick();
      boot_start = 1'b0;
    end
    chk("load_ready", 64'(ld_ready), 64'd1);
    chk("load_count0", 64'(ld_count), 64'd0);
    chk("load_fault_clr", 64'(seq_fault), 64'd0);
    chk("load_hold", 64'(core_hold), 64'd1);
    chk("load_run", 64'(core_run), 64'd0);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          ld_valid   = 1'b0;
          boot_start = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
          #1;
          chk("gap_en", 64'(mem_en), 64'd0);
          tick();
        end
        boot_start = 1'b0;
      end
      ld_valid = 1'b1;
      ld_data  = src[i];
      ld_last  = use_last && (i == n - 1);
      #1;
      if (i < DEPTH) begin
        chk("wr_en", 64'(mem_en), 64'd1);
        chk("wr_we", 64'(mem_we), 64'd1);
        chk("wr_addr", mem_addr, 64'(4 * i));
        chk("wr_data", 64'(mem_wdata), 64'(src[i]));
      end else begin
        chk("ovf_en", 64'(mem_en), 64'd0);
      end
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    bad = 0;
    for (int i = 0; i < nw; i++) if (imem[i] !== src[i]) bad++;
    chk("image_words", 64'(bad), 64'd0);
    chk("write_count", 64'(wr_cnt - w0), 64'(nw));
  endtask

  // Called in the SETTLE cycle right after the last transfer.
  task automatic finish_boot(input int n);
    pc_stall = 1'b0;
    pc_if    = {$urandom, $urandom};
    #1;
    chk("settle_en", 64'(mem_en), 64'd0);
    chk("settle_run", 64'(core_run), 64'd0);
    chk("settle_count", 64'(ld_count), 64'(n));
    tick();
    chk("boot_run", 64'(core_run), 64'd1);
    chk("boot_hold", 64'(core_hold), 64'd0);
    chk("boot_fault", 64'(seq_fault), 64'd0);
    chk("boot_count", 64'(ld_count), 64'(n));
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) src[i] = $urandom;
  endtask

  initial begin
    int n, w0;
    rstn = 1'b0; boot_start = 1'b0; ld_valid = 1'b1; ld_data = $urandom; ld_last = 1'b0;
    pc_if = '0; pc_stall = 1'b1; mem_fault = 1'b0;

    // Reset held with the loader pushing words.
    repeat (3) begin
      tick();
      chk("rst_hold", 64'(core_hold), 64'd1);
      chk("rst_run", 64'(core_run), 64'd0);
      chk("rst_ready", 64'(ld_ready), 64'd0);
      chk("rst_we", 64'(mem_we), 64'd0);
      chk("rst_en", 64'(mem_en), 64'd0);
      chk("rst_fault", 64'(seq_fault), 64'd0);
      chk("rst_count", 64'(ld_count), 64'd0);
      chk("rst_addr", mem_addr, 64'd0);
      ld_data = $urandom;
    end
    rstn = 1'b1;
    tick();
    chk("idle_ready", 64'(ld_ready), 64'd0);
    chk("idle_we", 64'(mem_we), 64'd0);
    chk("idle_writes", 64'(wr_cnt), 64'd0);
    ld_valid = 1'b0;

    // Directed 4-word image.
    src[0] = 32'h13; src[1] = 32'h93; src[2] = 32'h113; src[3] = 32'h193;
    load(4, 1'b1, 1'b0, 1'b0, 1'b0);
    finish_boot(4);
    pc_if = 64'd8;
    #1;
    chk("fetch_addr", mem_addr, 64'd8);
    chk("fetch_en", 64'(mem_en), 64'd1);
    chk("fetch_we", 64'(mem_we), 64'd0);

    // Random fetches with stalls.
    repeat (8) begin
      tick();
      pc_if    = {$urandom, $urandom};
      pc_stall = 1'($urandom_range(0, 1));
      #1;
      chk("rf_addr", mem_addr, pc_if);
      chk("rf_en", 64'(mem_en), 64'(!pc_stall));
      chk("rf_we", 64'(mem_we), 64'd0);
      chk("rf_run", 64'(core_run), 64'd1);
    end

    // Fetch fault.
    pc_stall  = 1'b0;
    mem_fault = 1'b1;
    tick();
    mem_fault = 1'b0;
    chk("flt_hold", 64'(core_hold), 64'd1);
    chk("flt_run", 64'(core_run), 64'd0);
    chk("flt_sticky", 64'(seq_fault), 64'd1);
    #1;
    chk("flt_en", 64'(mem_en), 64'd0);
    tick();
    chk("flt_sticky2", 64'(seq_fault), 64'd1);

    // Recovery with a 1-word image.
    fill_random(1);
    load(1, 1'b1, 1'b0, 1'b0, 1'b0);
    finish_boot(1);

    // Reload from RUN: random length, loader gaps, ignored boot_start pulses.
    n = $urandom_range(5, 20);
    fill_random(n);
    load(n, 1'b1, 1'b1, 1'b1, 1'b0);
    finish_boot(n);

    // Fault and reload in the same cycle: reload wins.
    boot_start = 1'b1;
    mem_fault  = 1'b1;
    tick();
    boot_start = 1'b0;
    mem_fault  = 1'b0;
    chk("race_fault", 64'(seq_fault), 64'd0);
    n = $urandom_range(2, 6);
    fill_random(n);
    load(n, 1'b1, 1'b1, 1'b0, 1'b1);
    finish_boot(n);

    // Overflow: DEPTH+1 words with no last marker.
    fill_random(DEPTH + 1);
    load(DEPTH + 1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_fault", 64'(seq_fault), 64'd1);
    chk("ovf_count", 64'(ld_count), 64'(DEPTH));
    chk("ovf_ready", 64'(ld_ready), 64'd0);
    chk("ovf_hold", 64'(core_hold), 64'd1);
    chk("ovf_run", 64'(core_run), 64'd0);

    // Exactly DEPTH words with last on the final one is legal.
    fill_random(DEPTH);
    load(DEPTH, 1'b1, 1'b1, 1'b0, 1'b0);
    finish_boot(DEPTH);

    // Reset in the middle of a load.
    fill_random(2);
    load(2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_count", 64'(ld_count), 64'd2);
    w0 = wr_cnt;
    rstn = 1'b0;
    ld_valid = 1'b1;
    ld_data = $urandom;
    #1;
    chk("mid_rst_we", 64'(mem_we), 64'd0);
    tick();
    rstn = 1'b1;
    chk("mid_count0", 64'(ld_count), 64'd0);
    chk("mid_ready", 64'(ld_ready), 64'd0);
    chk("mid_hold", 64'(core_hold), 64'd1);
    chk("mid_run", 64'(core_run), 64'd0);
    tick();
    ld_valid = 1'b0;
    chk("mid_idle_ready", 64'(ld_ready), 64'd0);
    chk("mid_no_write", 64'(wr_cnt - w0), 64'd0);
    chk("mid_kept0", 64'(imem[0]), 64'(src[0]));
    chk("mid_kept1", 64'(imem[1]), 64'(src[1]));
    chk("addr_range", 64'(bad_addr), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
